// File: rtl/align_pkg.sv
// Shared types and helpers for the fp32 mantissa alignment shifter.
package align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } align_state_e;

    // Working register layout: {hidden, mantissa, guard, round, sticky}
    localparam int unsigned GRS_W      = 3;
    localparam int unsigned GUARD_IDX  = 2;
    localparam int unsigned ROUND_IDX  = 1;
    localparam int unsigned STICKY_IDX = 0;

    function automatic int unsigned work_width(input int unsigned mant_w);
        return mant_w + GRS_W + 1;
    endfunction

    function automatic int unsigned min_step(input int unsigned rem, input int unsigned step);
        return (rem < step) ? rem : step;
    endfunction

endpackage

// File: rtl/sticky_shift_step.sv
// Combinational right shift by k (0..STEP); every bit shifted out is OR-collapsed into bit 0.
module sticky_shift_step #(
    parameter int unsigned W    = 27,
    parameter int unsigned STEP = 4,
    parameter int unsigned KW   = $clog2(STEP + 1)
) (
    input  logic [W-1:0]  work_in,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  work_out
);

    logic [W-1:0] prefix_or;
    logic [W-1:0] prefix_sel;

    // prefix_or[b] = |work_in[b:0]
    always_comb begin
        logic acc;
        acc = 1'b0;
        prefix_or = '0;
        for (int unsigned b = 0; b < W; b++) begin
            acc = acc | work_in[b];
            prefix_or[b] = acc;
        end
    end

    always_comb begin
        work_out   = work_in;
        prefix_sel = prefix_or;
        for (int unsigned j = 0; (j <= STEP) && (j < W); j++) begin
            if (k == KW'(j)) begin
                work_out    = work_in >> j;
                prefix_sel  = prefix_or >> j;
                work_out[0] = prefix_sel[0];
            end
        end
    end

endmodule

// File: rtl/align_shifter.sv
// Mantissa alignment shifter with guard/round/sticky tracking and start/done handshake.
// Optional macro ALIGN_SAT_BYPASS_EN: shift amounts >= W complete in one step.
module align_shifter
    import align_pkg::*;
#(
    parameter int unsigned MANT_W  = 23,
    parameter int unsigned SHAMT_W = 8,
    parameter int unsigned STEP    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               hidden_in,
    input  logic [MANT_W-1:0]  mant_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [MANT_W:0]    mant_out,
    output logic               guard,
    output logic               round,
    output logic               sticky
);

    localparam int unsigned W  = work_width(MANT_W);
    localparam int unsigned KW = $clog2(STEP + 1);

    align_state_e       state_q, state_d;
    logic [W-1:0]       work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [KW-1:0]      k_step;
    logic [W-1:0]       work_shifted;

    always_comb begin
        k_step = KW'(min_step(32'(rem_q), STEP));
    end

    sticky_shift_step #(
        .W    (W),
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .work_in  (work_q),
        .k        (k_step),
        .work_out (work_shifted)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = {hidden_in, mant_in, {GRS_W{1'b0}}};
                    rem_d   = shamt;
                    state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
`ifdef ALIGN_SAT_BYPASS_EN
                    // Everything would fall into sticky anyway; produce that result directly.
                    if (32'(shamt) >= W) begin
                        work_d             = '0;
                        work_d[STICKY_IDX] = |{hidden_in, mant_in};
                        rem_d              = '0;
                        state_d            = ST_DONE;
                    end
`endif
                end
            end
            ST_SHIFT: begin
                work_d = work_shifted;
                rem_d  = rem_q - SHAMT_W'(k_step);
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign mant_out = work_q[W-1:GRS_W];
    assign guard    = work_q[GUARD_IDX];
    assign round    = work_q[ROUND_IDX];
    assign sticky   = work_q[STICKY_IDX];

endmodule

// File: tb/tb_align_shifter.sv
// Self-checking bench for align_shifter: directed cases plus randomized operations vs. a reference model.
module tb_align_shifter;

    localparam int unsigned MANT_W  = 23;
    localparam int unsigned SHAMT_W = 8;
    localparam int unsigned STEP    = 4;
    localparam int unsigned W       = MANT_W + 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               hidden_in = 1'b0;
    logic [MANT_W-1:0]  mant_in = '0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic               busy;
    logic               done;
    logic [MANT_W:0]    mant_out;
    logic               guard;
    logic               round;
    logic               sticky;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    align_shifter #(
        .MANT_W  (MANT_W),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .hidden_in (hidden_in),
        .mant_in   (mant_in),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .mant_out  (mant_out),
        .guard     (guard),
        .round     (round),
        .sticky    (sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact right shift of the loaded value; anything shifted out lands in the sticky bit.
    function automatic logic [W-1:0] ref_align(input logic h, input logic [MANT_W-1:0] m,
                                               input int unsigned s);
        logic [W-1:0] full;
        logic [W-1:0] res;
        logic         lost;
        full = {h, m, 3'b000};
        if (s >= W) begin
            res    = '0;
            res[0] = |full;
            return res;
        end
        res    = full >> s;
        lost   = (s == 0) ? 1'b0 : |(full << (W - s));
        res[0] = res[0] | lost;
        return res;
    endfunction

    function automatic int unsigned exp_latency(input int unsigned s);
        if (s == 0) return 1;
`ifdef ALIGN_SAT_BYPASS_EN
        if (s >= W) return 1;
`endif
        return 1 + (s + STEP - 1) / STEP;
    endfunction

    task automatic scramble_inputs();
        hidden_in = 1'($urandom);
        mant_in   = 23'($urandom);
        shamt     = 8'($urandom);
    endtask

    task automatic run_op(input logic h, input logic [MANT_W-1:0] m, input logic [SHAMT_W-1:0] s);
        logic [W-1:0] exp_w;
        int unsigned  lat;
        int unsigned  n;
        exp_w = ref_align(h, m, 32'(s));
        lat   = exp_latency(32'(s));
        @(negedge clk);
        hidden_in = h;
        mant_in   = m;
        shamt     = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        n     = 1;
        start = 1'b0;
        scramble_inputs();
        check("busy_after_accept", 32'(busy), 32'd1);
        while (!done && n < 400) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
            scramble_inputs();
        end
        check("latency", n, lat);
        check("mant_out", 32'(mant_out), 32'(exp_w[W-1:3]));
        check("guard", 32'(guard), 32'(exp_w[2]));
        check("round", 32'(round), 32'(exp_w[1]));
        check("sticky", 32'(sticky), 32'(exp_w[0]));
        // A start raised during the done cycle must not be accepted.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_single_pulse", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("hold_mant_out", 32'(mant_out), 32'(exp_w[W-1:3]));
        check("hold_sticky", 32'(sticky), 32'(exp_w[0]));
    endtask

    initial begin
        logic [MANT_W-1:0] rm;
        logic [SHAMT_W-1:0] rs;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mant_out", 32'(mant_out), 32'd0);
        check("rst_grs", {29'd0, guard, round, sticky}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_start", 32'(busy), 32'd0);

        run_op(1'b1, 23'h000000, 8'd0);
        run_op(1'b1, 23'h000000, 8'd1);
        run_op(1'b1, 23'h000001, 8'd3);
        run_op(1'b1, 23'h7FFFFF, 8'd30);
        run_op(1'b1, 23'h2AAAAA, 8'd9);
        run_op(1'b0, 23'h000000, 8'd200);
        run_op(1'b0, 23'h000001, 8'd26);
        run_op(1'b1, 23'h000000, 8'd27);
        run_op(1'b1, 23'h7FFFFF, 8'd255);

        // Reset in the middle of a shift discards the operation.
        @(negedge clk);
        hidden_in = 1'b1;
        mant_in   = 23'h5A5A5A;
        shamt     = 8'd20;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_mant_out", 32'(mant_out), 32'd0);
        check("midrst_grs", {29'd0, guard, round, sticky}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_idle", 32'(busy), 32'd0);
        run_op(1'b1, 23'h123456, 8'd0);

        for (int i = 0; i < 30; i++) begin
            rm = 23'($urandom);
            if ($urandom_range(0, 9) == 0) rs = 8'($urandom_range(27, 255));
            else rs = 8'($urandom_range(0, 30));
            run_op(1'($urandom), rm, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
